// File: rtl/text_row_scanner.sv
// Text row scanner: buffers one line of character codes, then serializes glyph
// rows pixel by pixel through an external font ROM. Macro TEXT_ROW_SCANNER_GAP_EN adds a blank 7th pixel per cell.
module text_row_scanner #(
  parameter int CHARS_PER_LINE = 16,
  parameter int GLYPH_ROWS     = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_char,
  input  logic       i_char_valid,
  output logic       o_char_ready,
  output logic [5:0] o_font_char,
  output logic [3:0] o_font_row,
  input  logic [5:0] i_font_raster,
  input  logic       i_pix_en,
  output logic       o_pixel,
  output logic       o_pixel_valid,
  output logic       o_row_start,
  output logic       o_line_done
);

  localparam int CW = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;
`ifdef TEXT_ROW_SCANNER_GAP_EN
  localparam int CELL_W = 7;
`else
  localparam int CELL_W = 6;
`endif

  typedef enum logic [1:0] {FILL, SCAN, DONE} state_t;

  state_t        state, nxt;
  logic [CW-1:0] col;
  logic [3:0]    row;
  logic [2:0]    bitc;
  logic          last_px;
  logic          strobe, cur_bit;
  logic          pix_q, vld_q, rs_q;
  logic          col_last, row_last, bit_last;
  logic [5:0]    line_buf [CHARS_PER_LINE];

  assign col_last = (col == CW'(CHARS_PER_LINE - 1));
  assign row_last = (row == 4'(GLYPH_ROWS - 1));
  assign bit_last = (bitc == 3'(CELL_W - 1));

  // Once the final pixel is out, further strobes are ignored until DONE.
  assign strobe = (state == SCAN) && !last_px && i_pix_en;

`ifdef TEXT_ROW_SCANNER_GAP_EN
  assign cur_bit = (bitc == 3'd6) ? 1'b0 : i_font_raster[3'd5 - bitc];
`else
  assign cur_bit = i_font_raster[3'd5 - bitc];
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= FILL;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      FILL:    if (i_char_valid && col_last) nxt = SCAN;
      SCAN:    if (last_px) nxt = DONE;
      DONE:    nxt = FILL;
      default: nxt = FILL;
    endcase
  end

  always_comb begin
    o_char_ready  = (state == FILL);
    o_line_done   = (state == DONE);
    o_font_char   = (state == SCAN) ? line_buf[col] : 6'd0;
    o_font_row    = (state == SCAN) ? row : 4'd0;
    o_pixel       = pix_q;
    o_pixel_valid = vld_q;
    o_row_start   = rs_q;
  end

  always_ff @(posedge i_clk) begin
    if (state == FILL && i_char_valid) line_buf[col] <= i_char;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col     <= '0;
      row     <= '0;
      bitc    <= '0;
      last_px <= 1'b0;
      pix_q   <= 1'b0;
      vld_q   <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      vld_q <= strobe;
      pix_q <= strobe & cur_bit;
      rs_q  <= strobe && (col == '0) && (bitc == '0);
      case (state)
        FILL: begin
          last_px <= 1'b0;
          if (i_char_valid) col <= col_last ? '0 : col + 1'b1;
        end
        SCAN: begin
          // bit -> col -> row odometer, one step per accepted strobe
          if (strobe) begin
            if (!bit_last) bitc <= bitc + 3'd1;
            else begin
              bitc <= '0;
              if (!col_last) col <= col + 1'b1;
              else begin
                col <= '0;
                if (!row_last) row <= row + 4'd1;
                else begin
                  row     <= '0;
                  last_px <= 1'b1;
                end
              end
            end
          end
        end
        default: begin
          col     <= '0;
          row     <= '0;
          bitc    <= '0;
          last_px <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_row_scanner.sv
// Randomized bench for text_row_scanner: pixel stream compared with a line/row/col
// model computed directly from the buffered codes and a ROM function.
module tb_text_row_scanner;
  localparam int CPL = 16;
  localparam int GR  = 8;
`ifdef TEXT_ROW_SCANNER_GAP_EN
  localparam int CELL = 7;
`else
  localparam int CELL = 6;
`endif
  localparam int TOTAL = CPL * GR * CELL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] ch = '0;
  logic       ch_valid = 1'b0;
  logic       ready;
  logic [5:0] font_char;
  logic [3:0] font_row;
  logic [5:0] raster;
  logic       pix_en = 1'b0;
  logic       pixel, pixel_valid, row_start, line_done;

  int errors = 0;
  int checks = 0;
  logic [5:0] linebuf [CPL];

  always #5 clk = ~clk;

  text_row_scanner #(.CHARS_PER_LINE(CPL), .GLYPH_ROWS(GR)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_char(ch), .i_char_valid(ch_valid),
    .o_char_ready(ready), .o_font_char(font_char), .o_font_row(font_row),
    .i_font_raster(raster), .i_pix_en(pix_en), .o_pixel(pixel),
    .o_pixel_valid(pixel_valid), .o_row_start(row_start), .o_line_done(line_done)
  );

  function automatic logic [5:0] rom(input logic [5:0] c, input logic [3:0] r);
    logic [7:0] h;
    h = {2'b00, c} * 8'd37 + {4'b0000, r} * 8'd11 + 8'h2b;
    return h[5:0] ^ {r[1:0], c[5:2]};
  endfunction

  assign raster = rom(font_char, font_row);

  // Expected value of the n-th pixel of the line (row-major, cell by cell).
  function automatic logic exp_pix(input int n);
    int r, c, b;
    logic [5:0] g;
    r = n / (CPL * CELL);
    c = (n / CELL) % CPL;
    b = n % CELL;
    if (b > 5) return 1'b0;
    g = rom(linebuf[c], r[3:0]);
    return g[5-b];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ch_valid = 1'b0; pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pixel_valid); end
    checks++; if (font_char !== 6'd0) begin errors++; $display("FAIL reset_font_char: got %0d want 0", font_char); end
    checks++; if (font_row !== 4'd0) begin errors++; $display("FAIL reset_font_row: got %0d want 0", font_row); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset_line_done: got %b want 0", line_done); end
    rst_n = 1'b1;
  endtask

  // mode 0: codes 0..CPL-1 back to back; otherwise random codes with idle gaps
  task automatic test_fill(input int mode);
    int hs = 0, cyc = 0;
    while (hs < CPL && cyc < 1000) begin
      ch_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ch = (mode == 0) ? 6'(hs) : 6'($urandom_range(0, 63));
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fill_ready: got %b want 1 at hs=%0d", ready, hs); end
      @(posedge clk);
      if (ch_valid) begin linebuf[hs] = ch; hs++; end
      #1; cyc++;
    end
    ch_valid = 1'b0;
    checks++; if (hs !== CPL) begin errors++; $display("FAIL fill_count: got %0d want %0d", hs, CPL); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fill_done_ready: got %b want 0", ready); end
    checks++; if (font_char !== linebuf[0]) begin errors++; $display("FAIL fill_font_char: got %0d want %0d", font_char, linebuf[0]); end
    checks++; if (font_row !== 4'd0) begin errors++; $display("FAIL fill_font_row: got %0d want 0", font_row); end
  endtask

  // mode 0: continuous strobe; 1: toggling; 2: random
  task automatic test_scan(input int mode);
    int n = 0, cyc = 0, rs = 0;
    logic en;
    logic [5:0] c1 = '0;
    while (n < TOTAL && cyc < TOTAL * 8) begin
      en = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      pix_en = en;
      @(posedge clk); #1; cyc++;
      checks++; if (pixel_valid !== en) begin errors++; $display("FAIL scan_valid: got %b want %b at n=%0d", pixel_valid, en, n); end
      if (pixel_valid === 1'b1) begin
        checks++;
        if (pixel !== exp_pix(n) || row_start !== (n % (CPL * CELL) == 0)) begin
          errors++;
          $display("FAIL scan_pixel: got pix=%b rs=%b want pix=%b rs=%b at n=%0d",
                   pixel, row_start, exp_pix(n), (n % (CPL * CELL) == 0), n);
        end
        if (row_start === 1'b1) rs++;
        if (n >= CELL && n < CELL + 6) c1[5-(n-CELL)] = pixel;
        n++;
      end
      checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL scan_early_done: got %b want 0 at n=%0d", line_done, n); end
    end
    checks++; if (n !== TOTAL) begin errors++; $display("FAIL scan_count: got %0d want %0d", n, TOTAL); end
    checks++; if (rs !== GR) begin errors++; $display("FAIL scan_row_starts: got %0d want %0d", rs, GR); end
    checks++; if (c1 !== rom(linebuf[1], 4'd0)) begin errors++; $display("FAIL scan_char1_row0: got %b want %b", c1, rom(linebuf[1], 4'd0)); end
    pix_en = 1'b1;  // extra strobes after the last pixel must be ignored
    @(posedge clk); #1;
    checks++; if (line_done !== 1'b1) begin errors++; $display("FAIL eol_done: got %b want 1", line_done); end
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL eol_valid: got %b want 0", pixel_valid); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL eol_ready: got %b want 0", ready); end
    @(posedge clk); #1;
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL eol_pulse_len: got %b want 0", line_done); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL eol_new_line: got %b want 1", ready); end
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL eol_fill_valid: got %b want 0", pixel_valid); end
    pix_en = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int n = 0, cyc = 0;
    int stop_at = (3 * CPL + 7) * CELL;
    pix_en = 1'b1;
    while (n < stop_at && cyc < TOTAL * 2) begin
      @(posedge clk); #1; cyc++;
      if (pixel_valid === 1'b1) begin
        checks++; if (pixel !== exp_pix(n)) begin errors++; $display("FAIL abort_pixel: got %b want %b at n=%0d", pixel, exp_pix(n), n); end
        n++;
      end
    end
    checks++; if (n !== stop_at) begin errors++; $display("FAIL abort_reach: got %0d want %0d", n, stop_at); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", ready); end
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", pixel_valid); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", line_done); end
    checks++; if (font_row !== 4'd0) begin errors++; $display("FAIL abort_font_row: got %0d want 0", font_row); end
    rst_n = 1'b1; pix_en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (line_done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL abort_after: got done=%b ready=%b want 0/1", line_done, ready); end
    end
  endtask

  initial begin
    test_reset();
    test_fill(0);
    test_scan(0);
    test_fill(1);
    test_scan(1);
    test_fill(1);
    test_scan(2);
    test_fill(1);
    test_reset_mid_scan();
    test_fill(1);      // back-to-back lines after the aborted one
    test_scan(0);
    test_fill(1);
    test_scan(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
